// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection (sequential, BEQ, jump),
// and the IF/ID register that feeds decode. Halts on an out-of-range PC until reset.
module pc_fetch_unit #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump_en,
    input  logic [25:0] jump_target,
    input  logic [31:0] instruction,
    output logic [31:0] program_counter,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus1,
    output logic        if_valid,
    output logic        pc_error
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t             state;
    logic        [31:0] pc_p0;
    logic        [31:0] pc_plus1_p0;
    logic signed [31:0] offset_sext_p0;
    logic        [31:0] next_pc_p0;
    logic               redirect_p0;
    logic               out_of_range_p0;
    logic        [31:0] instr_p1;
    logic        [31:0] pc_plus1_p1;
    logic               vld_p1;
    logic               err_q;

    assign pc_plus1_p0    = pc_p0 + 32'd1;
    assign offset_sext_p0 = {{16{branch_offset[15]}}, branch_offset};
    assign redirect_p0    = jump_en | branch_taken;

    // Jump outranks branch; either redirect outranks stall.
    always_comb begin
        next_pc_p0 = pc_plus1_p0;
        if (jump_en)
            next_pc_p0 = {pc_plus1_p0[31:26], jump_target};
        else if (branch_taken)
            next_pc_p0 = pc_plus1_p0 + offset_sext_p0;
        else if (stall)
            next_pc_p0 = pc_p0;
    end

    assign out_of_range_p0 = (next_pc_p0 >= 32'(MEM_DEPTH));

    // Stage boundary: PC (p0) -> IF/ID register (p1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc_p0       <= RESET_PC;
            instr_p1    <= '0;
            pc_plus1_p1 <= '0;
            vld_p1      <= 1'b0;
            err_q       <= 1'b0;
        end else if (state == RUN) begin
            pc_p0 <= next_pc_p0;
            if (out_of_range_p0) begin
                err_q  <= 1'b1;
                state  <= HALT;
                vld_p1 <= 1'b0;
            end else if (flush || redirect_p0) begin
                vld_p1   <= 1'b0;
                instr_p1 <= '0;
            end else if (!stall) begin
                instr_p1    <= instruction;
                pc_plus1_p1 <= pc_plus1_p0;
                vld_p1      <= 1'b1;
            end
        end
    end

    assign program_counter = pc_p0;
    assign if_instr        = instr_p1;
    assign if_pc_plus1     = pc_plus1_p1;
    assign if_valid        = vld_p1;
    assign pc_error        = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural instruction memory (mem[i] = i+100).
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump_en;
    logic [25:0] jump_target;
    logic [31:0] instruction;
    logic [31:0] program_counter;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus1;
    logic        if_valid;
    logic        pc_error;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit #(.MEM_DEPTH(256), .RESET_PC(32'd0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .branch_taken    (branch_taken),
        .branch_offset   (branch_offset),
        .jump_en         (jump_en),
        .jump_target     (jump_target),
        .instruction     (instruction),
        .program_counter (program_counter),
        .if_instr        (if_instr),
        .if_pc_plus1     (if_pc_plus1),
        .if_valid        (if_valid),
        .pc_error        (pc_error)
    );

    assign instruction = (program_counter < 32'd256) ? program_counter + 32'd100 : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 0; flush = 0; branch_taken = 0; branch_offset = '0;
        jump_en = 0; jump_target = '0;
    endtask

    task automatic expect_if(input string tag, input logic [31:0] pc,
                             input logic [31:0] ins, input logic [31:0] pp1, input logic v);
        check({tag, ".pc"},   program_counter, pc);
        check({tag, ".ins"},  if_instr, ins);
        check({tag, ".pp1"},  if_pc_plus1, pp1);
        check({tag, ".vld"},  {31'd0, if_valid}, {31'd0, v});
    endtask

    initial begin
        idle();
        rst_n = 0;
        #3;
        expect_if("rst", 0, 0, 0, 0);
        check("rst.err", {31'd0, pc_error}, 32'd0);

        @(negedge clk);
        rst_n = 1;

        // Sequential fetch
        step(); expect_if("seq1", 1, 100, 1, 1);
        step(); expect_if("seq2", 2, 101, 2, 1);
        step(); expect_if("seq3", 3, 102, 3, 1);
        step(); expect_if("seq4", 4, 103, 4, 1);

        // Stall for three cycles at PC=4
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_if("stall", 4, 103, 4, 1);
        end
        stall = 0;
        step(); expect_if("resume", 5, 104, 5, 1);

        // BEQ at PC=5, offset -3 -> 3
        branch_taken = 1; branch_offset = 16'hFFFD;
        step(); expect_if("beq", 3, 0, 5, 0);
        idle();
        step(); expect_if("beq+1", 4, 103, 4, 1);

        // Branch beats stall: PC=4, offset +1 -> 6
        stall = 1; branch_taken = 1; branch_offset = 16'd1;
        step(); expect_if("brstall", 6, 0, 4, 0);
        idle();
        step(); expect_if("brstall+1", 7, 106, 7, 1);

        // Jump at PC=7 to 200
        jump_en = 1; jump_target = 26'd200;
        step(); expect_if("jmp", 200, 0, 7, 0);
        idle();
        step(); expect_if("jmp+1", 201, 300, 201, 1);

        // Jump beats branch
        jump_en = 1; jump_target = 26'd10; branch_taken = 1; branch_offset = 16'd5;
        step(); expect_if("jmpbr", 10, 0, 201, 0);
        idle();
        step(); expect_if("jmpbr+1", 11, 110, 11, 1);

        // Flush: bubble, pc_plus1 held, PC advances
        flush = 1;
        step(); expect_if("flush", 12, 0, 11, 0);
        idle();
        step(); expect_if("flush+1", 13, 112, 13, 1);

        // Out-of-range branch at PC=254 -> 260, halt
        jump_en = 1; jump_target = 26'd254;
        step(); check("to254.pc", program_counter, 254);
        idle();
        branch_taken = 1; branch_offset = 16'd5;
        step();
        check("oor.pc", program_counter, 260);
        check("oor.err", {31'd0, pc_error}, 32'd1);
        check("oor.vld", {31'd0, if_valid}, 32'd0);
        idle();
        step(); step();
        check("halt.pc", program_counter, 260);
        check("halt.err", {31'd0, pc_error}, 32'd1);
        check("halt.vld", {31'd0, if_valid}, 32'd0);

        // Asynchronous reset mid-cycle
        #2 rst_n = 0;
        #1;
        expect_if("arst", 0, 0, 0, 0);
        check("arst.err", {31'd0, pc_error}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Boundary: last legal word 255, then 256 halts
        jump_en = 1; jump_target = 26'd255;
        step(); expect_if("to255", 255, 0, 0, 0);
        check("to255.err", {31'd0, pc_error}, 32'd0);
        idle();
        step();
        check("edge.pc", program_counter, 256);
        check("edge.err", {31'd0, pc_error}, 32'd1);
        check("edge.vld", {31'd0, if_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
